// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo_pkg : shared constants and sizing helpers for the FWFT FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int C_DEF_DATA_WIDTH = 32;
  localparam int C_DEF_FIFO_DEPTH = 256;

  // Count must represent 0..depth inclusive, hence one bit above the address.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth > 0) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_mem_2p : dual-port storage, synchronous write, asynchronous read
// Revision 1.0
// ---------------------------------------------------------------------------
module fifo_mem_2p #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                          i_clk,
  input  logic                          i_we,
  input  logic [$clog2(FIFO_DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  input  logic [$clog2(FIFO_DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]         o_rdata
);

  // No reset so the array can map onto distributed/block RAM.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule : fifo_mem_2p
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo_fwft : single-clock first-word-fall-through FIFO with occupancy,
//                  thresholds, flush and high-water statistic
// Revision 1.0
// ---------------------------------------------------------------------------
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = C_DEF_DATA_WIDTH,
  parameter  int FIFO_DEPTH = C_DEF_FIFO_DEPTH,
  localparam int CNT_W      = cnt_width(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_clr_stat,
  input  logic                  i_valid_s,
  input  logic [DATA_WIDTH-1:0] i_datain,
  output logic                  o_ready_s,
  output logic                  o_valid_m,
  output logic [DATA_WIDTH-1:0] o_dataout,
  input  logic                  i_ready_m,
  input  logic [CNT_W-1:0]      i_almostfull_lvl,
  input  logic [CNT_W-1:0]      i_almostempty_lvl,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almostfull,
  output logic                  o_almostempty,
  output logic [CNT_W-1:0]      o_count,
  output logic [CNT_W-1:0]      o_max_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  generate
    if ((FIFO_DEPTH < 2) || !is_pow2(FIFO_DEPTH)) begin : g_depth_check
      $error("sync_fifo_fwft: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      max_count_q, max_count_d;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Flags come straight from the registered count, never from the handshake.
  assign o_full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign o_empty       = (count_q == '0);
  assign o_almostfull  = (count_q >= i_almostfull_lvl);
  assign o_almostempty = (count_q <= i_almostempty_lvl);
  assign o_ready_s     = !o_full;
  assign o_valid_m     = !o_empty;
  assign o_count       = count_q;
  assign o_max_count   = max_count_q;

  assign w_push = i_valid_s & o_ready_s;
  assign w_pop  = o_valid_m & i_ready_m;
  // A flushed cycle discards its push, so the array stays untouched.
  assign w_we   = w_push & !i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Clearing reloads the current occupancy so the statistic stays truthful.
  always_comb begin
    max_count_d = max_count_q;
    if (i_clr_stat) begin
      max_count_d = count_d;
    end else if (count_d > max_count_q) begin
      max_count_d = count_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      max_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      max_count_q <= max_count_d;
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_datain),
    .i_raddr (rd_ptr_q),
    .o_rdata (w_rdata)
  );

  assign o_dataout = o_valid_m ? w_rdata : '0;

endmodule : sync_fifo_fwft
`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft : directed self-checking bench, DATA_WIDTH=8, FIFO_DEPTH=8
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_sync_fifo_fwft;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, clr_stat, valid_s, ready_m;
  logic [DW-1:0] datain;
  logic [CW-1:0] af_lvl, ae_lvl;
  logic          ready_s, valid_m, full, empty, almostfull, almostempty;
  logic [DW-1:0] dataout;
  logic [CW-1:0] count, max_count;

  int errors = 0;
  int checks = 0;

  sync_fifo_fwft #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DP)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_flush           (flush),
    .i_clr_stat        (clr_stat),
    .i_valid_s         (valid_s),
    .i_datain          (datain),
    .o_ready_s         (ready_s),
    .o_valid_m         (valid_m),
    .o_dataout         (dataout),
    .i_ready_m         (ready_m),
    .i_almostfull_lvl  (af_lvl),
    .i_almostempty_lvl (ae_lvl),
    .o_full            (full),
    .o_empty           (empty),
    .o_almostfull      (almostfull),
    .o_almostempty     (almostempty),
    .o_count           (count),
    .o_max_count       (max_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ready_s"}, 32'(ready_s), 32'd1);
    chk({tag, "_valid_m"}, 32'(valid_m), 32'd0);
    chk({tag, "_dataout"}, 32'(dataout), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_max"}, 32'(max_count), 32'd0);
    chk({tag, "_aempty"}, 32'(almostempty), 32'd1);
    chk({tag, "_afull"}, 32'(almostfull), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] exp_q [8];

    rst_n = 1'b0; flush = 1'b0; clr_stat = 1'b0; valid_s = 1'b0; ready_m = 1'b0;
    datain = '0; af_lvl = 4'd6; ae_lvl = 4'd1;
    step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // First-word fall-through latency
    valid_s = 1'b1; datain = 8'h11;
    step();
    valid_s = 1'b0;
    chk("fwft_valid", 32'(valid_m), 32'd1);
    chk("fwft_data", 32'(dataout), 32'h11);
    chk("fwft_count", 32'(count), 32'd1);
    chk("fwft_aempty", 32'(almostempty), 32'd1);
    ready_m = 1'b1;
    step();
    ready_m = 1'b0;
    chk("pop_empty", 32'(empty), 32'd1);

    // Fill with consumer stalled
    for (int i = 0; i < 8; i++) begin
      valid_s = 1'b1; datain = 8'(i);
      step();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almostfull), 32'((i + 1) >= 6));
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_ready", 32'(ready_s), 32'd0);
    datain = 8'hAA;
    step();
    chk("stall_count", 32'(count), 32'd8);
    chk("stall_head", 32'(dataout), 32'h00);

    // Pop at full with push presented: only the pop happens
    ready_m = 1'b1;
    step();
    chk("popfull_count", 32'(count), 32'd7);
    chk("popfull_ready", 32'(ready_s), 32'd1);
    ready_m = 1'b0;
    step();
    valid_s = 1'b0;
    chk("refill_count", 32'(count), 32'd8);
    chk("max_full", 32'(max_count), 32'd8);

    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hAA};
    ready_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(dataout), 32'(exp_q[i]));
      step();
    end
    ready_m = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_dataout0", 32'(dataout), 32'd0);

    // Steady streaming at occupancy 3 across pointer wraps
    for (int i = 0; i < 3; i++) begin
      valid_s = 1'b1; datain = 8'(8'h20 + i);
      step();
    end
    valid_s = 1'b0; clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    chk("clr_to_count", 32'(max_count), 32'd3);
    valid_s = 1'b1; ready_m = 1'b1;
    for (int k = 0; k < 20; k++) begin
      datain = 8'(8'h23 + k);
      chk("stream_head", 32'(dataout), 32'(8'h20 + k));
      step();
      chk("stream_count", 32'(count), 32'd3);
    end
    valid_s = 1'b0;
    chk("stream_max", 32'(max_count), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("stream_tail", 32'(dataout), 32'(8'h34 + k));
      step();
    end
    ready_m = 1'b0;

    // Flush discards the concurrent push and keeps the statistic
    for (int i = 0; i < 5; i++) begin
      valid_s = 1'b1; datain = 8'(8'h40 + i);
      step();
    end
    chk("pre_flush_count", 32'(count), 32'd5);
    datain = 8'h55; flush = 1'b1;
    step();
    flush = 1'b0; valid_s = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_dataout", 32'(dataout), 32'd0);
    chk("flush_max", 32'(max_count), 32'd5);
    step();
    chk("flush_no55", 32'(valid_m), 32'd0);
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    chk("clr_max", 32'(max_count), 32'd0);

    // Threshold follows level changes in the same cycle
    af_lvl = 4'd0;
    #1;
    chk("afull_lvl0", 32'(almostfull), 32'd1);
    af_lvl = 4'd9;
    #1;
    chk("afull_lvl9", 32'(almostfull), 32'd0);
    af_lvl = 4'd6;

    // Asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) begin
      valid_s = 1'b1; datain = 8'(8'h60 + i);
      step();
    end
    valid_s = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd4);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    #1;
    rst_n = 1'b1;
    step();
    valid_s = 1'b1; datain = 8'h77;
    step();
    valid_s = 1'b0;
    chk("post_rst_data", 32'(dataout), 32'h77);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sync_fifo_fwft
`default_nettype wire
